// File: rtl/dft_pkg.sv
// Shared constants, read-FSM state and sample type for the DFT input buffer.
// Pure declarations: no latency, no flow control.
package dft_pkg;
  localparam int N_DFT    = 12;
  localparam int SAMPLE_W = 16;
  localparam int IDX_W    = 5;

  typedef enum logic [1:0] {IDLE, START, BUSY} rd_state_e;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } sample_t;
endpackage

// File: rtl/dft_12_bank.sv
// N-entry complex register file: synchronous write, combinational read.
// Out-of-range read index returns 0; no flow control (write enable only).
module dft_12_bank
  import dft_pkg::*;
#(
  parameter int N  = N_DFT,
  parameter int DW = SAMPLE_W,
  parameter int IW = IDX_W
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   waddr,
  input  logic signed [DW-1:0]   wre,
  input  logic signed [DW-1:0]   wim,
  input  logic [IW-1:0]          raddr,
  output logic signed [DW-1:0]   rre,
  output logic signed [DW-1:0]   rim
);
  localparam int AW = $clog2(N);

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[waddr] <= wre;
      mem_im[waddr] <= wim;
    end
  end

  // The range check makes the truncated index safe.
  assign rre = (raddr < IW'(N)) ? mem_re[raddr[AW-1:0]] : '0;
  assign rim = (raddr < IW'(N)) ? mem_im[raddr[AW-1:0]] : '0;
endmodule

// File: rtl/dft_12_in_buf.sv
// Ping-pong block buffer ahead of the 12-point DFT; o_start two cycles after the 12th write, read data combinational.
// o_ready drops only when both banks hold unread blocks; samples offered then are dropped and flag o_ovf.
module dft_12_in_buf
  import dft_pkg::*;
#(
  parameter int N  = N_DFT,
  parameter int DW = SAMPLE_W,
  parameter int IW = IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_sof,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic                 o_ready,
  output logic                 o_ovf,
  output logic                 o_start,
  input  logic [IW-1:0]        i_n,
  input  logic                 i_done_all,
  output logic signed [DW-1:0] o_re,
  output logic signed [DW-1:0] o_im,
  output logic                 o_busy
);
  localparam int AW = $clog2(N);

  rd_state_e     state;
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_idx;
  logic          start_q;
  logic          busy_q;
  logic          ovf_q;

  logic          hs;
  logic          wr_last;
  logic          release_bank;
  logic [AW-1:0] waddr;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;
  logic signed [DW-1:0] re0, im0, re1, im1;

  assign o_ready      = !rst && !full[wr_bank];
  assign hs           = i_valid && o_ready;
  assign waddr        = i_sof ? '0 : wr_idx;
  assign wr_last      = hs && !i_sof && (wr_idx == AW'(N-1));
  assign release_bank = (state == BUSY) && i_done_all;
  assign full_set     = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr     = release_bank ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (i_valid && !o_ready) ovf_q <= 1'b1;
      if (hs) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= waddr + AW'(1);
        end
      end
      // Completion and release always target different banks.
      full <= (full | full_set) & ~full_clr;
      case (state)
        IDLE: begin
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          if (full[rd_bank]) begin
            state   <= START;
            start_q <= 1'b1;
          end
        end
        START: begin
          state   <= BUSY;
          start_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        BUSY: begin
          if (i_done_all) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            rd_bank <= ~rd_bank;
          end
        end
        default: begin
          state   <= IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_start = start_q && !rst;
  assign o_busy  = busy_q && !rst;
  assign o_ovf   = ovf_q && !rst;

  dft_12_bank #(.N(N), .DW(DW), .IW(IW)) u_bank0 (
    .clk(clk), .we(hs && !wr_bank), .waddr(waddr), .wre(i_re), .wim(i_im),
    .raddr(i_n), .rre(re0), .rim(im0)
  );

  dft_12_bank #(.N(N), .DW(DW), .IW(IW)) u_bank1 (
    .clk(clk), .we(hs && wr_bank), .waddr(waddr), .wre(i_re), .wim(i_im),
    .raddr(i_n), .rre(re1), .rim(im1)
  );

  assign o_re = (state != IDLE) ? (rd_bank ? re1 : re0) : '0;
  assign o_im = (state != IDLE) ? (rd_bank ? im1 : im0) : '0;
endmodule

// File: tb/tb_dft_12_in_buf.sv
// Bench for dft_12_in_buf: randomized streams against a block-queue reference model.
module tb_dft_12_in_buf;
  import dft_pkg::*;

  typedef sample_t blk_t [N_DFT];
  typedef struct { blk_t d; int t; } fblk_t;
  typedef struct { logic sof; sample_t s; } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0, i_sof = 1'b0, i_done_all = 1'b0;
  logic signed [SAMPLE_W-1:0] i_re = '0, i_im = '0;
  logic [IDX_W-1:0] i_n = '0;
  logic o_ready, o_ovf, o_start, o_busy;
  logic signed [SAMPLE_W-1:0] o_re, o_im;

  always #5 clk = ~clk;

  dft_12_in_buf dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof), .i_re(i_re), .i_im(i_im),
    .o_ready(o_ready), .o_ovf(o_ovf), .o_start(o_start), .i_n(i_n),
    .i_done_all(i_done_all), .o_re(o_re), .o_im(o_im), .o_busy(o_busy)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  stim_t stim_q[$];
  fblk_t exp_q[$];
  blk_t part, cur;
  int pcnt = 0, occ = 0, last_done = -100, pass_start = 0, pass_len = 0, n_starts = 0;
  int acc_re = 0, acc_im = 0;
  bit in_pass = 0, ovf_exp = 0, done_lvl = 0, honour = 1, gapless = 1, saw_not_ready = 0;

  // Reference: blocks complete in order, a block occupies a bank until its DFT pass ends,
  // a pass starts 2 cycles after both the block exists and the previous pass has finished.
  task automatic step();
    bit want, exp_rdy, act;
    int start_due, k, ni, sr, si;
    sample_t exp_s;
    blk_t blk;
    exp_rdy = (occ < 2);
    start_due = -1;
    if (!in_pass && exp_q.size() > 0)
      start_due = ((exp_q[0].t > last_done) ? exp_q[0].t : last_done) + 2;
    want = (stim_q.size() > 0) && (!honour || exp_rdy) && (gapless || $urandom_range(0, 3) != 0);
    i_valid = want;
    i_sof   = want ? stim_q[0].sof : 1'b0;
    i_re    = want ? stim_q[0].s.re : SAMPLE_W'($urandom);
    i_im    = want ? stim_q[0].s.im : SAMPLE_W'($urandom);
    k = cyc - pass_start - 1;
    if (in_pass) begin
      i_n = (k < N_DFT) ? IDX_W'(k) : IDX_W'($urandom_range(0, 15));
      i_done_all = (k == pass_len);
    end else begin
      i_n = IDX_W'($urandom_range(0, 15));
      i_done_all = done_lvl;
    end

    @(negedge clk);
    if (!o_ready) saw_not_ready = 1;
    n_cmp++;
    if (o_ready !== exp_rdy) begin n_bad++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_ready, exp_rdy); end
    n_cmp++;
    if (o_start !== (cyc == start_due)) begin n_bad++; $display("FAIL start cyc=%0d got=%b exp=%b", cyc, o_start, cyc == start_due); end
    n_cmp++;
    if (o_busy !== in_pass) begin n_bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, in_pass); end
    n_cmp++;
    if (o_ovf !== ovf_exp) begin n_bad++; $display("FAIL ovf cyc=%0d got=%b exp=%b", cyc, o_ovf, ovf_exp); end
    act = (cyc == start_due) || in_pass;
    if (cyc == start_due) blk = exp_q[0].d; else blk = cur;
    ni = int'(i_n);
    exp_s = (act && ni < N_DFT) ? blk[ni] : '0;
    n_cmp++;
    if (o_re !== exp_s.re || o_im !== exp_s.im) begin
      n_bad++; $display("FAIL data cyc=%0d n=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, ni, o_re, o_im, exp_s.re, exp_s.im);
    end
    if (in_pass && k < N_DFT) begin acc_re += int'(o_re); acc_im += int'(o_im); end

    if (i_valid && !exp_rdy) ovf_exp = 1;
    if (i_valid && exp_rdy) begin
      if (i_sof) pcnt = 0;
      part[pcnt] = {i_re, i_im};
      pcnt++;
      if (pcnt == N_DFT) begin
        fblk_t fb;
        fb.d = part; fb.t = cyc;
        exp_q.push_back(fb);
        pcnt = 0; occ++;
      end
    end
    if (want) void'(stim_q.pop_front());
    if (in_pass && i_done_all) begin
      // Bin-0 of the DFT is the plain sum of the block.
      sr = 0; si = 0;
      for (int j = 0; j < N_DFT; j++) begin sr += int'(cur[j].re); si += int'(cur[j].im); end
      n_cmp++;
      if (acc_re !== sr || acc_im !== si) begin
        n_bad++; $display("FAIL bin0 cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, acc_re, acc_im, sr, si);
      end
      in_pass = 0; occ--; last_done = cyc; done_lvl = 1;
    end else if (cyc == start_due) begin
      cur = exp_q[0].d;
      void'(exp_q.pop_front());
      in_pass = 1; pass_start = cyc; pass_len = N_DFT + $urandom_range(0, 6);
      done_lvl = 0; n_starts++; acc_re = 0; acc_im = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(int ncyc);
    rst = 1; i_valid = 0; i_sof = 0; i_done_all = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_start !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0 || o_ovf !== 1'b0) begin
        n_bad++; $display("FAIL in_reset cyc=%0d got start/busy/ready/ovf=%b%b%b%b exp=0000", cyc, o_start, o_busy, o_ready, o_ovf);
      end
      @(posedge clk); #1;
      cyc++;
    end
    rst = 0;
    stim_q.delete(); exp_q.delete();
    pcnt = 0; occ = 0; in_pass = 0; ovf_exp = 0; done_lvl = 0; last_done = -100;
  endtask

  task automatic push_sample(logic sof, int re, int im);
    stim_t st;
    st.sof = sof; st.s.re = SAMPLE_W'(re); st.s.im = SAMPLE_W'(im);
    stim_q.push_back(st);
  endtask

  task automatic drain(int budget);
    int b = budget;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || in_pass) && b > 0) begin step(); b--; end
    if (b == 0) begin n_cmp++; n_bad++; $display("FAIL drain_timeout cyc=%0d got=expired exp=drained", cyc); end
    repeat (3) step();
  endtask

  task automatic test_reset();
    do_reset(3);
    step();
    step();
  endtask

  task automatic test_ramp();
    honour = 1; gapless = 1;
    for (int n = 0; n < N_DFT; n++) push_sample(n == 0, n + 1, -(n + 1));
    drain(200);
  endtask

  task automatic test_dc();
    honour = 1; gapless = 0;
    for (int n = 0; n < N_DFT; n++) push_sample(n == 0, 100, 0);
    drain(300);
  endtask

  task automatic test_back_to_back();
    int s0 = n_starts;
    honour = 1; gapless = 1; saw_not_ready = 0;
    for (int n = 0; n < 3 * N_DFT; n++) push_sample(n % N_DFT == 0, $urandom_range(0, 65535), $urandom_range(0, 65535));
    drain(600);
    n_cmp++;
    if (n_starts - s0 !== 3) begin n_bad++; $display("FAIL b2b_starts got=%0d exp=3", n_starts - s0); end
    n_cmp++;
    if (!saw_not_ready) begin n_bad++; $display("FAIL b2b_backpressure got=ready_always exp=ready_low_seen"); end
  endtask

  task automatic test_sof_restart();
    honour = 1; gapless = 0;
    for (int n = 0; n < 5; n++) push_sample(n == 0, 7000 + n, -7000 - n);
    for (int n = 0; n < N_DFT; n++) push_sample(n == 0, 300 + n, 400 + n);
    drain(400);
  endtask

  task automatic test_overflow();
    honour = 0; gapless = 1;
    for (int n = 0; n < 3 * N_DFT; n++) push_sample(n % N_DFT == 0, $urandom_range(0, 65535), $urandom_range(0, 65535));
    drain(600);
    n_cmp++;
    if (o_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", o_ovf); end
  endtask

  task automatic test_reset_busy();
    int b = 200;
    honour = 1; gapless = 1;
    for (int n = 0; n < N_DFT; n++) push_sample(n == 0, $urandom_range(0, 65535), $urandom_range(0, 65535));
    while (!(in_pass && cyc > pass_start + 3) && b > 0) begin step(); b--; end
    if (b == 0) begin n_cmp++; n_bad++; $display("FAIL busy_timeout cyc=%0d got=expired exp=busy", cyc); end
    do_reset(2);
    for (int n = 0; n < N_DFT; n++) push_sample(n == 0, $urandom_range(0, 65535), $urandom_range(0, 65535));
    drain(300);
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_ramp();
    test_dc();
    test_back_to_back();
    test_sof_restart();
    test_overflow();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
